// File: rtl/ai_layer_sequencer.sv
// Layer sequencer for the 32x32 broadcast-MAC MMU: loads host features, runs dense
// layers 0..3 through the MMU, requantizes hidden results in place, returns layer-3 neuron 0.
module ai_layer_sequencer #(
    parameter int AW    = 8,
    parameter int ACCW  = 18,
    parameter int N_IN  = 4,
    parameter int DIM   = 32,
    parameter int SHIFT = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    input  logic [AW-1:0]   in_data,
    output logic            in_ready,
    output logic            result_valid,
    output logic [ACCW-1:0] result,
    output logic            busy,
    output logic            err,
    output logic            mmu_start,
    output logic [1:0]      mmu_layer_sel,
    output logic            mmu_act_valid,
    output logic [AW-1:0]   mmu_act_in,
    input  logic            mmu_res_valid,
    input  logic [ACCW-1:0] mmu_res_out,
    input  logic            mmu_done
);

    localparam int IW = $clog2(DIM);
    localparam logic [AW-1:0]   QMAX   = {1'b0, {(AW-1){1'b1}}};
    localparam logic [ACCW-1:0] QMAX_W = ACCW'(QMAX);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_START, S_FEED, S_COLLECT, S_OUTPUT
    } state_t;

    state_t           r_state, w_next;
    logic [IW-1:0]    r_idx;
    logic [IW-1:0]    r_fcnt;
    logic [IW:0]      r_bcnt;
    logic [1:0]       r_layer;
    logic [ACCW-1:0]  r_result;
    logic             r_err;
    logic [AW-1:0]    r_abuf [DIM];

    logic             w_accept;
    logic [IW-1:0]    w_feat_idx;
    logic             w_last_feat;
    logic             w_cnt_ok;

    function automatic logic [AW-1:0] requant(input logic [ACCW-1:0] v);
        logic signed [ACCW-1:0] s;
        s = $signed(v) >>> SHIFT;
        if (s[ACCW-1])
            return '0;
        if ($unsigned(s) > QMAX_W)
            return QMAX;
        return s[AW-1:0];
    endfunction

    assign w_accept    = in_valid && in_ready;
    assign w_feat_idx  = (r_state == S_IDLE) ? '0 : r_fcnt;
    assign w_last_feat = (w_feat_idx == IW'(N_IN - 1));
    // Beat count includes a result beat arriving in the same cycle as done.
    assign w_cnt_ok    = ((IW+2)'(r_bcnt) + (IW+2)'(mmu_res_valid)) == (IW+2)'(DIM);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:    if (w_accept) w_next = w_last_feat ? S_START : S_LOAD;
            S_LOAD:    if (w_accept && w_last_feat) w_next = S_START;
            S_START:   w_next = S_FEED;
            S_FEED:    if (r_idx == IW'(DIM - 1)) w_next = S_COLLECT;
            S_COLLECT: if (mmu_done) w_next = (r_layer == 2'd3) ? S_OUTPUT : S_START;
            S_OUTPUT:  w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready      = (r_state == S_IDLE) || (r_state == S_LOAD);
        mmu_start     = (r_state == S_START);
        mmu_act_valid = (r_state == S_FEED);
        result_valid  = (r_state == S_OUTPUT);
        busy          = (r_state != S_IDLE);
        mmu_act_in    = '0;
        if (r_state == S_FEED) begin
            // Layer 0 only has N_IN real inputs; the rest of the MMU row is zero-padded.
            if (r_layer == 2'd0 && {1'b0, r_idx} >= (IW+1)'(N_IN))
                mmu_act_in = '0;
            else
                mmu_act_in = r_abuf[r_idx];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idx    <= '0;
            r_fcnt   <= '0;
            r_bcnt   <= '0;
            r_layer  <= '0;
            r_result <= '0;
            r_err    <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE, S_LOAD: begin
                    if (w_accept) begin
                        r_fcnt <= w_feat_idx + 1'b1;
                        if (w_last_feat)
                            r_layer <= '0;
                    end
                end
                S_START: begin
                    r_idx  <= '0;
                    r_bcnt <= '0;
                end
                S_FEED: begin
                    r_idx <= (r_idx == IW'(DIM - 1)) ? '0 : r_idx + 1'b1;
                end
                S_COLLECT: begin
                    if (mmu_res_valid) begin
                        if (r_layer == 2'd3 && r_idx == '0)
                            r_result <= mmu_res_out;
                        r_idx <= r_idx + 1'b1;
                        if (r_bcnt != '1)
                            r_bcnt <= r_bcnt + 1'b1;
                    end
                    if (mmu_done) begin
                        if (!w_cnt_ok)
                            r_err <= 1'b1;
                        if (r_layer != 2'd3)
                            r_layer <= r_layer + 1'b1;
                        r_idx <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Feed of a layer always completes before its first result, so one write port suffices.
    always_ff @(posedge clk) begin
        if (w_accept)
            r_abuf[w_feat_idx] <= in_data;
        else if (r_state == S_COLLECT && mmu_res_valid && r_layer != 2'd3)
            r_abuf[r_idx] <= requant(mmu_res_out);
    end

    assign result        = r_result;
    assign err           = r_err;
    assign mmu_layer_sel = r_layer;

endmodule

// File: doc/ai_layer_sequencer.md
# ai_layer_sequencer

Layer sequencer for the 32×32 broadcast-MAC MMU in the AI accelerator. It accepts one 4-feature input vector from the host, drives the MMU through dense layers 0→3, and requantizes each layer's 32 results back into an on-chip activation buffer that feeds the next layer. It returns the final signed output-layer value to the host. It sits between the host activation stream and the MMU's start/act/result ports and owns `layer_sel` for the whole inference.

## Interface

Parameters:
- `AW`, default 8: activation width; matches MMU `AW`.
- `ACCW`, default 18: MMU result width.
- `N_IN`, default 4: number of input features.
- `DIM`, default 32: MMU `IN_DIM` / `OUT_DIM`.
- `SHIFT`, default 4: requantization right-shift applied to hidden-layer results.

Ports:
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `in_valid` in 1: host feature beat valid.
- `in_data` in AW: host feature, signed.
- `in_ready` out 1: sequencer accepts a feature beat.
- `result_valid` out 1: one-cycle pulse when `result` holds the final output.
- `result` out ACCW: signed layer-3 neuron-0 output, held until the next `result_valid`.
- `busy` out 1: high from the first accepted feature until `result_valid`, inclusive.
- `err` out 1: sticky result-count error; cleared only by reset.
- `mmu_start` out 1: start pulse to the MMU.
- `mmu_layer_sel` out 2: layer select to the MMU.
- `mmu_act_valid` out 1: activation beat valid to the MMU.
- `mmu_act_in` out AW: activation to the MMU.
- `mmu_res_valid` in 1: MMU result beat valid.
- `mmu_res_out` in ACCW: MMU result.
- `mmu_done` in 1: MMU last-result pulse.

## Operation

**Storage**
- `abuf`: DIM×AW activation buffer, written in place.
- Layer k's feed phase always finishes before its first result arrives, so read and write of `abuf` never overlap.

**State machine**
- **IDLE**
  - `in_ready`=1.
  - On an accepted beat: write `abuf[0]`, set `fcnt`=1, go to LOAD.
- **LOAD**
  - `in_ready`=1.
  - Each accepted beat writes `abuf[fcnt]` and increments `fcnt`.
  - On accepting beat N_IN−1: set `layer`=0 and go to START.
  - Gaps in `in_valid` are allowed.
- **START**
  - `mmu_start`=1 for exactly one cycle, `idx`=0, then go to FEED.
- **FEED**
  - `mmu_act_valid`=1 for DIM consecutive cycles with `mmu_act_in`=`abuf[idx]`.
  - Exception: when `layer`==0 and `idx`≥N_IN, drive 0 instead of `abuf[idx]`.
  - After the beat with `idx`==DIM−1, clear `idx` and go to COLLECT.
- **COLLECT**
  - Each `mmu_res_valid` beat updates buffer/result by layer:
    - layer<3: write `abuf[idx]` = `requant(mmu_res_out)`.
    - layer==3: when `idx`==0, capture `mmu_res_out` into `result`.
  - Each beat then increments `idx`.
  - On `mmu_done`:
    - If the total beat count, including the done-cycle beat, ≠ DIM, set `err`. Proceed regardless.
    - layer<3: `layer`++ and go to START.
    - layer==3: go to OUTPUT.
- **OUTPUT**
  - `result_valid`=1 for one cycle, then go to IDLE.

**Rules**
- `requant(v)` = clamp(v >>> SHIFT, 0, 2^(AW−1)−1). The shift is arithmetic on the signed ACCW value.
- Layer 3 output is not requantized and keeps full ACCW signed width.
- `mmu_layer_sel`=`layer`, held constant from START through the last COLLECT cycle of that layer. The MMU selects weights combinationally from it.
- `mmu_res_valid`/`mmu_done` outside COLLECT are ignored.
- `mmu_act_valid`=0 and `mmu_act_in`=0 outside FEED.

## Timing

- **Reset values:** state IDLE; `in_ready`=1 (combinational from IDLE); all other outputs 0, including `result`=0 and `err`=0; `layer`=0; `idx`=0; `fcnt`=0.
- **Reset mid-operation:**
  - Everything returns to IDLE immediately.
  - `abuf` contents are don't-care.
  - The MMU is expected to be reset by the same signal.
- **Layer cycle offsets.** Let S_k be the cycle in which `mmu_start`=1 for layer k.
  - Act beats: S_k+1 … S_k+32.
  - Expected MMU response: `mmu_res_valid` S_k+34 … S_k+65, with `mmu_done` at S_k+65.
  - Next start: S_{k+1} = S_k+66.
- **Inference latency:**
  - S_0 is the cycle after the last feature is accepted.
  - `result_valid` at S_3+66 = S_0+264.
  - `busy` drops the cycle after `result_valid`.
- `in_ready` is 0 from START through OUTPUT, so a beat offered mid-inference is held off.

## Test plan

- **Reset:** assert `reset` mid-FEED of layer 1 → next cycle all outputs at reset values, `in_ready`=1; a fresh 4-beat load then runs normally.
- **Full inference with an MMU behavioural model:** features {10,−3,0,127} → exactly 4 `mmu_start` pulses.
  - `mmu_layer_sel` sequence 0,1,2,3.
  - Each layer has 32 contiguous act beats.
  - Layer-0 beats 4..31 are 0.
  - `result_valid` occurs at S_0+264.
  - `result` equals the golden-model output.
- **Requant boundaries:** model returns for layer 0:
  - `mmu_res_out`=2047 → layer-1 beat = 127.
  - 16 → 1.
  - 15 → 0.
  - −5 → 0.
  - 131071 → 127.
- **Layer 3 signed output:** model returns −200 at idx 0 and junk at idx 1..31 → `result`=−200 (0x3FF38 in 18 bits), no clamping.
- **Result-count error:** model asserts `mmu_done` after 31 beats in layer 2 → `err`=1 and stays 1; layer 3 still starts at S_2+65+1.
- **Input backpressure:** `in_valid` toggling 1,0,1,0,1,1 → `abuf[0..3]` holds beats 0..3 in order. A 5th beat offered during FEED sees `in_ready`=0 and is not consumed.
